handshake_latency_monitor: RTL and testbench

Synthesisable multi-channel checker for the rule "rising start must be followed by rising ready within a latency window".
Runs in hardware alongside DUT handshakes and mirrors the team's start/ready SVA checks in gate-level and FPGA builds, where assertions are unavailable.
Per channel it reports pass/early/late/overlap events, the measured latency and a saturating failure count.

---
 rtl/handshake_latency_monitor_pkg.sv | 37 +++
 rtl/handshake_latency_monitor_if.sv | 37 +++
 rtl/handshake_latency_monitor_channel.sv | 142 ++++++++++++++
 rtl/handshake_latency_monitor.sv | 102 ++++++++++
 tb/tb_handshake_latency_monitor.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_latency_monitor_pkg.sv
// ---------------------------------------------------------------------------
// hlm_pkg
// Shared types and helpers for the handshake latency monitor.
//   hlm_state_e  : per-channel FSM state (IDLE, WAIT)
//   hlm_result_e : result of one channel evaluation at a clock edge
//   sat_inc      : saturating increment for the per-channel failure counters
//   is_error     : true for every result that counts as a failure
// ---------------------------------------------------------------------------
package hlm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hlm_state_e;

    typedef enum logic [2:0] {
        RES_NONE,
        RES_PASS,
        RES_EARLY,
        RES_LATE,
        RES_OVERLAP,
        RES_SPUR
    } hlm_result_e;

    // Counters are handled at 32 bits and cut back to their own width by the
    // caller, so one function serves every CNT_W up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_val);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

    function automatic logic is_error(input hlm_result_e res);
        return (res == RES_EARLY) || (res == RES_LATE) ||
               (res == RES_OVERLAP) || (res == RES_SPUR);
    endfunction

endpackage

// File: rtl/handshake_latency_monitor_if.sv
// ---------------------------------------------------------------------------
// handshake_latency_monitor_if
// Bundles the monitored start/ready levels, the clear strobe and all monitor
// results.
//   master : drives start, ready, clr; observes the results
//   slave  : the monitor itself
// lat_out / fail_cnt are packed per channel: channel i at [i*W +: W].
// ---------------------------------------------------------------------------
interface handshake_latency_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       ready;
    logic                    clr;
    logic [NUM_CH-1:0]       pass;
    logic [NUM_CH-1:0]       err_early;
    logic [NUM_CH-1:0]       err_late;
    logic [NUM_CH-1:0]       err_overlap;
    logic [NUM_CH-1:0]       err_spur;
    logic [NUM_CH*LAT_W-1:0] lat_out;
    logic [NUM_CH*CNT_W-1:0] fail_cnt;
    logic                    err_sticky;

    modport master (
        output start, ready, clr,
        input  pass, err_early, err_late, err_overlap, err_spur,
        input  lat_out, fail_cnt, err_sticky
    );

    modport slave (
        input  start, ready, clr,
        output pass, err_early, err_late, err_overlap, err_spur,
        output lat_out, fail_cnt, err_sticky
    );
endinterface

// File: rtl/handshake_latency_monitor_channel.sv
// ---------------------------------------------------------------------------
// hlm_channel
// One start->ready latency checker: IDLE/WAIT FSM, window counter, last
// latency and saturating failure counter. All result outputs are registered
// one-cycle pulses.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_start_rise, i_ready_rise  edge events from the top-level edge registers
//   i_clr                       synchronous clear of the failure counter
//   o_pass/o_early/o_late/o_overlap/o_spur  result pulses
//   o_err_evt                   combinational: an error is decided this edge
//   o_lat, o_fail_cnt           last WAIT latency, failure count
// Optional feature macro: MONITOR_SPURIOUS_EN (ready rise in IDLE is an error).
// ---------------------------------------------------------------------------
module hlm_channel
    import hlm_pkg::*;
#(
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 8,
    parameter int LAT_W   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_rise,
    input  logic             i_ready_rise,
    input  logic             i_clr,
    output logic             o_pass,
    output logic             o_early,
    output logic             o_late,
    output logic             o_overlap,
    output logic             o_spur,
    output logic             o_err_evt,
    output logic [LAT_W-1:0] o_lat,
    output logic [CNT_W-1:0] o_fail_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hlm_state_e       r_state;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_fail;
    logic             r_pass;
    logic             r_early;
    logic             r_late;
    logic             r_overlap;
    hlm_result_e      w_res;
    logic             w_err;

    // Ready is evaluated before start so a simultaneous rise of both closes
    // the current window normally; the late check only applies when neither
    // edge is present.
    always_comb begin
        w_res = RES_NONE;
        case (r_state)
            IDLE: begin
`ifdef MONITOR_SPURIOUS_EN
                if (i_ready_rise) w_res = RES_SPUR;
`endif
            end
            WAIT: begin
                if (i_ready_rise)
                    w_res = (r_cnt >= LAT_W'(MIN_LAT)) ? RES_PASS : RES_EARLY;
                else if (i_start_rise)
                    w_res = RES_OVERLAP;
                else if (r_cnt == LAT_W'(MAX_LAT))
                    w_res = RES_LATE;
            end
            default: w_res = RES_NONE;
        endcase
    end

    assign w_err = is_error(w_res);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_fail    <= '0;
            r_pass    <= 1'b0;
            r_early   <= 1'b0;
            r_late    <= 1'b0;
            r_overlap <= 1'b0;
        end else begin
            r_pass    <= (w_res == RES_PASS);
            r_early   <= (w_res == RES_EARLY);
            r_late    <= (w_res == RES_LATE);
            r_overlap <= (w_res == RES_OVERLAP);

            // clr wins over an error decided at the same edge.
            if (i_clr)
                r_fail <= '0;
            else if (w_err)
                r_fail <= CNT_W'(sat_inc(32'(r_fail), 32'(CNT_MAX)));

            case (r_state)
                IDLE: begin
                    if (i_start_rise) begin
                        r_state <= WAIT;
                        r_cnt   <= LAT_W'(1);
                    end
                end
                WAIT: begin
                    if (i_ready_rise) begin
                        r_lat <= r_cnt;
                        if (i_start_rise) r_cnt   <= LAT_W'(1);
                        else              r_state <= IDLE;
                    end else if (i_start_rise) begin
                        r_cnt <= LAT_W'(1);
                    end else if (r_cnt == LAT_W'(MAX_LAT)) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + LAT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MONITOR_SPURIOUS_EN
    logic r_spur;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_spur <= 1'b0;
        else          r_spur <= (w_res == RES_SPUR);
    end
    assign o_spur = r_spur;
`else
    assign o_spur = 1'b0;
`endif

    assign o_pass     = r_pass;
    assign o_early    = r_early;
    assign o_late     = r_late;
    assign o_overlap  = r_overlap;
    assign o_err_evt  = w_err;
    assign o_lat      = r_lat;
    assign o_fail_cnt = r_fail;

endmodule

// File: rtl/handshake_latency_monitor.sv
// ---------------------------------------------------------------------------
// handshake_latency_monitor
// Multi-channel hardware checker: every rising start must be followed by a
// rising ready within [MIN_LAT, MAX_LAT] cycles. Holds the start/ready edge
// registers, one hlm_channel per channel, and the sticky error flag.
// Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous, active-low reset
//   bus  handshake_latency_monitor_if.slave (start, ready, clr in; pass,
//        err_early, err_late, err_overlap, err_spur, lat_out, fail_cnt,
//        err_sticky out)
// Optional feature macro: MONITOR_SPURIOUS_EN.
// ---------------------------------------------------------------------------
module handshake_latency_monitor
    import hlm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    handshake_latency_monitor_if.slave    bus
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);

    if (MIN_LAT < 1 || MAX_LAT < MIN_LAT) begin : g_param_chk
        $error("handshake_latency_monitor: need 1 <= MIN_LAT <= MAX_LAT");
    end

    logic [NUM_CH-1:0]       r_start_q;
    logic [NUM_CH-1:0]       r_ready_q;
    logic                    r_sticky;
    logic [NUM_CH-1:0]       w_start_rise;
    logic [NUM_CH-1:0]       w_ready_rise;
    logic [NUM_CH-1:0]       w_pass;
    logic [NUM_CH-1:0]       w_early;
    logic [NUM_CH-1:0]       w_late;
    logic [NUM_CH-1:0]       w_overlap;
    logic [NUM_CH-1:0]       w_spur;
    logic [NUM_CH-1:0]       w_err;
    logic [NUM_CH*LAT_W-1:0] w_lat;
    logic [NUM_CH*CNT_W-1:0] w_fail;

    // Edge registers clear to 0, so a level already high at the first edge
    // after reset release counts as a rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q <= '0;
            r_ready_q <= '0;
        end else begin
            r_start_q <= bus.start;
            r_ready_q <= bus.ready;
        end
    end

    assign w_start_rise = bus.start & ~r_start_q;
    assign w_ready_rise = bus.ready & ~r_ready_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hlm_channel #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT),
            .CNT_W   (CNT_W),
            .LAT_W   (LAT_W)
        ) u_ch (
            .i_clk        (clk),
            .i_rst_n      (rst),
            .i_start_rise (w_start_rise[g]),
            .i_ready_rise (w_ready_rise[g]),
            .i_clr        (bus.clr),
            .o_pass       (w_pass[g]),
            .o_early      (w_early[g]),
            .o_late       (w_late[g]),
            .o_overlap    (w_overlap[g]),
            .o_spur       (w_spur[g]),
            .o_err_evt    (w_err[g]),
            .o_lat        (w_lat[g*LAT_W +: LAT_W]),
            .o_fail_cnt   (w_fail[g*CNT_W +: CNT_W])
        );
    end

    // Set from the pre-register error decision so the flag rises on the same
    // edge as the error pulse; clr drops errors of its own cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_sticky <= 1'b0;
        else if (bus.clr)  r_sticky <= 1'b0;
        else if (|w_err)   r_sticky <= 1'b1;
    end

    assign bus.pass        = w_pass;
    assign bus.err_early   = w_early;
    assign bus.err_late    = w_late;
    assign bus.err_overlap = w_overlap;
    assign bus.err_spur    = w_spur;
    assign bus.lat_out     = w_lat;
    assign bus.fail_cnt    = w_fail;
    assign bus.err_sticky  = r_sticky;

endmodule

// File: tb/tb_handshake_latency_monitor.sv
module tb_handshake_latency_monitor;
    import hlm_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int MIN_LAT = 2;
    localparam int MAX_LAT = 4;
    localparam int CNT_W   = 2;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef struct {
        int          cyc;
        int          ch;
        hlm_result_e kind;
        int          lat;
        bit          chk_lat;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  exp_q[$];

    handshake_latency_monitor_if #(.NUM_CH(NUM_CH), .LAT_W(LAT_W), .CNT_W(CNT_W)) hif ();

    handshake_latency_monitor #(
        .NUM_CH(NUM_CH), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int ch);
        return int'(hif.lat_out[ch*LAT_W +: LAT_W]);
    endfunction

    function automatic int cnt_of(input int ch);
        return int'(hif.fail_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input int ch, input hlm_result_e k,
                             input int lat, input bit chk_lat);
        ev_t e;
        e.cyc = c; e.ch = ch; e.kind = k; e.lat = lat; e.chk_lat = chk_lat;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every observed result pulse pops the oldest expectation.
    logic [4:0]  mon_bits;
    hlm_result_e mon_kind;
    int          mon_lat;
    ev_t         mon_e;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mon_bits = {hif.err_spur[c], hif.err_overlap[c], hif.err_late[c],
                            hif.err_early[c], hif.pass[c]};
                if (mon_bits != 5'd0) begin
                    case (mon_bits)
                        5'b00001: mon_kind = RES_PASS;
                        5'b00010: mon_kind = RES_EARLY;
                        5'b00100: mon_kind = RES_LATE;
                        5'b01000: mon_kind = RES_OVERLAP;
                        5'b10000: mon_kind = RES_SPUR;
                        default:  mon_kind = RES_NONE;
                    endcase
                    mon_lat = lat_of(c);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected: ch=%0d cyc=%0d got kind=%s lat=%0d, expected no event",
                                 c, cyc, mon_kind.name(), mon_lat);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.cyc !== cyc || mon_e.ch !== c || mon_e.kind !== mon_kind ||
                            (mon_e.chk_lat && mon_e.lat !== mon_lat))
                            $display("FAIL sb_event: got ch=%0d cyc=%0d kind=%s lat=%0d, expected ch=%0d cyc=%0d kind=%s lat=%0d",
                                     c, cyc, mon_kind.name(), mon_lat,
                                     mon_e.ch, mon_e.cyc, mon_e.kind.name(), mon_e.lat);
                        else
                            n_pass++;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        hif.start = '0; hif.ready = '0; hif.clr = 1'b0;
        tick(2);
        n_checks++;
        if ({hif.pass, hif.err_early, hif.err_late, hif.err_overlap, hif.err_spur} !== '0)
            $display("FAIL reset_pulses: got %h, expected 0",
                     {hif.pass, hif.err_early, hif.err_late, hif.err_overlap, hif.err_spur});
        else n_pass++;
        n_checks++;
        if (hif.lat_out !== '0) $display("FAIL reset_lat: got %h, expected 0", hif.lat_out);
        else n_pass++;
        n_checks++;
        if (hif.fail_cnt !== '0) $display("FAIL reset_fail_cnt: got %h, expected 0", hif.fail_cnt);
        else n_pass++;
        n_checks++;
        if (hif.err_sticky !== 1'b0) $display("FAIL reset_sticky: got %b, expected 0", hif.err_sticky);
        else n_pass++;
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_pass();
        int n;
        hif.start[0] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 3, 0, RES_PASS, 3, 1'b1);
        tick(3);
        hif.ready[0] = 1'b1;
        tick(1);
        n_checks++;
        if (lat_of(0) !== 3) $display("FAIL pass_lat: got %0d, expected 3", lat_of(0));
        else n_pass++;
        hif.start[0] = 1'b0; hif.ready[0] = 1'b0;
        tick(3);
        n_checks++;
        if (cnt_of(0) !== 0) $display("FAIL pass_fail_cnt: got %0d, expected 0", cnt_of(0));
        else n_pass++;
        n_checks++;
        if (hif.err_sticky !== 1'b0) $display("FAIL pass_sticky: got %b, expected 0", hif.err_sticky);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL pass_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_early();
        int n;
        hif.start[0] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 1, 0, RES_EARLY, 1, 1'b1);
        tick(1);
        hif.ready[0] = 1'b1;
        tick(1);
        n_checks++;
        if (lat_of(0) !== 1) $display("FAIL early_lat: got %0d, expected 1", lat_of(0));
        else n_pass++;
        n_checks++;
        if (cnt_of(0) !== 1) $display("FAIL early_fail_cnt: got %0d, expected 1", cnt_of(0));
        else n_pass++;
        n_checks++;
        if (hif.err_sticky !== 1'b1) $display("FAIL early_sticky: got %b, expected 1", hif.err_sticky);
        else n_pass++;
        hif.start[0] = 1'b0; hif.ready[0] = 1'b0;
        tick(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL early_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_late_spur();
        int n;
        int exp_cnt;
        hif.start[2] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 4, 2, RES_LATE, 0, 1'b0);
        tick(1);
        hif.start[2] = 1'b0;
        tick(5);
        hif.ready[2] = 1'b1;
`ifdef MONITOR_SPURIOUS_EN
        expect_ev(n + 6, 2, RES_SPUR, 0, 1'b0);
        exp_cnt = 2;
`else
        exp_cnt = 1;
`endif
        tick(1);
        hif.ready[2] = 1'b0;
        tick(3);
        n_checks++;
        if (cnt_of(2) !== exp_cnt) $display("FAIL late_fail_cnt: got %0d, expected %0d", cnt_of(2), exp_cnt);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL late_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_overlap();
        int n;
        hif.start[1] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 2, 1, RES_OVERLAP, 0, 1'b0);
        expect_ev(n + 5, 1, RES_PASS, 3, 1'b1);
        tick(1);
        hif.start[1] = 1'b0;
        tick(1);
        hif.start[1] = 1'b1;
        tick(1);
        hif.start[1] = 1'b0;
        tick(2);
        hif.ready[1] = 1'b1;
        tick(1);
        n_checks++;
        if (lat_of(1) !== 3) $display("FAIL overlap_lat: got %0d, expected 3", lat_of(1));
        else n_pass++;
        hif.ready[1] = 1'b0;
        tick(2);
        n_checks++;
        if (cnt_of(1) !== 1) $display("FAIL overlap_fail_cnt: got %0d, expected 1", cnt_of(1));
        else n_pass++;
        // Second run: ready and start rise together closes one window and opens the next.
        hif.start[1] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 3, 1, RES_PASS, 3, 1'b1);
        expect_ev(n + 5, 1, RES_PASS, 2, 1'b1);
        tick(1);
        hif.start[1] = 1'b0;
        tick(2);
        hif.start[1] = 1'b1; hif.ready[1] = 1'b1;
        tick(1);
        hif.start[1] = 1'b0; hif.ready[1] = 1'b0;
        tick(1);
        hif.ready[1] = 1'b1;
        tick(1);
        n_checks++;
        if (lat_of(1) !== 2) $display("FAIL b2b_lat: got %0d, expected 2", lat_of(1));
        else n_pass++;
        hif.ready[1] = 1'b0;
        tick(3);
        n_checks++;
        if (cnt_of(1) !== 1) $display("FAIL b2b_fail_cnt: got %0d, expected 1", cnt_of(1));
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL overlap_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_multi_channel();
        int n;
        hif.start = 4'b1111;
        n = cyc + 1;
        expect_ev(n + 1, 2, RES_EARLY, 1, 1'b1);
        expect_ev(n + 2, 0, RES_PASS, 2, 1'b1);
        expect_ev(n + 4, 1, RES_PASS, 4, 1'b1);
        expect_ev(n + 4, 3, RES_LATE, 0, 1'b0);
        tick(1);
        hif.start = 4'b0000;
        hif.ready[2] = 1'b1;
        tick(1);
        hif.ready[0] = 1'b1;
        tick(2);
        hif.ready[1] = 1'b1;
        tick(1);
        n_checks++;
        if ({lat_of(2), lat_of(1), lat_of(0)} !== {32'd1, 32'd4, 32'd2})
            $display("FAIL multi_lat: got ch0=%0d ch1=%0d ch2=%0d, expected 2 4 1",
                     lat_of(0), lat_of(1), lat_of(2));
        else n_pass++;
        n_checks++;
        if (cnt_of(3) !== 1) $display("FAIL multi_fail_cnt3: got %0d, expected 1", cnt_of(3));
        else n_pass++;
        hif.ready = 4'b0000;
        tick(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL multi_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_saturate_clr();
        int n;
        for (int i = 0; i < 5; i++) begin
            hif.start[3] = 1'b1;
            n = cyc + 1;
            expect_ev(n + 4, 3, RES_LATE, 0, 1'b0);
            tick(1);
            hif.start[3] = 1'b0;
            tick(5);
        end
        n_checks++;
        if (cnt_of(3) !== 3) $display("FAIL sat_fail_cnt: got %0d, expected 3", cnt_of(3));
        else n_pass++;
        hif.start[3] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 3, 3, RES_PASS, 3, 1'b1);
        tick(1);
        hif.start[3] = 1'b0;
        hif.clr = 1'b1;
        tick(1);
        hif.clr = 1'b0;
        n_checks++;
        if (hif.fail_cnt !== '0) $display("FAIL clr_fail_cnt: got %h, expected 0", hif.fail_cnt);
        else n_pass++;
        n_checks++;
        if (hif.err_sticky !== 1'b0) $display("FAIL clr_sticky: got %b, expected 0", hif.err_sticky);
        else n_pass++;
        tick(1);
        hif.ready[3] = 1'b1;
        tick(1);
        n_checks++;
        if (lat_of(3) !== 3) $display("FAIL clr_keeps_fsm_lat: got %0d, expected 3", lat_of(3));
        else n_pass++;
        hif.ready[3] = 1'b0;
        tick(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL sat_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        hif.start[3] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 1, 3, RES_EARLY, 1, 1'b1);
        tick(1);
        hif.start[3] = 1'b0; hif.ready[3] = 1'b1; hif.start[0] = 1'b1;
        tick(1);
        hif.start[1] = 1'b1;
        tick(1);
        hif.start[2] = 1'b1;
        tick(1);
        n_checks++;
        if (hif.err_sticky !== 1'b1 || cnt_of(3) !== 1)
            $display("FAIL pre_reset_state: got sticky=%b cnt3=%0d, expected 1 1", hif.err_sticky, cnt_of(3));
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({hif.pass, hif.err_early, hif.err_late, hif.err_overlap, hif.err_spur,
             hif.lat_out, hif.fail_cnt, hif.err_sticky} !== '0)
            $display("FAIL mid_reset_outputs: got lat=%h cnt=%h sticky=%b, expected all 0",
                     hif.lat_out, hif.fail_cnt, hif.err_sticky);
        else n_pass++;
        hif.start = '0; hif.ready = '0;
        tick(2);
        rst = 1'b1;
        tick(6);
        n_checks++;
        if (exp_q.size() != 0 || hif.fail_cnt !== '0) begin
            $display("FAIL post_reset_stale: got pending=%0d cnt=%h, expected 0 0", exp_q.size(), hif.fail_cnt);
            exp_q.delete();
        end else n_pass++;
        hif.start[0] = 1'b1;
        n = cyc + 1;
        expect_ev(n + 2, 0, RES_PASS, 2, 1'b1);
        tick(2);
        hif.ready[0] = 1'b1;
        tick(1);
        n_checks++;
        if (lat_of(0) !== 2) $display("FAIL post_reset_lat: got %0d, expected 2", lat_of(0));
        else n_pass++;
        hif.start[0] = 1'b0; hif.ready[0] = 1'b0;
        tick(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL post_reset_missing: got %0d pending events, expected 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pass();
        test_early();
        test_late_spur();
        test_overlap();
        test_multi_channel();
        test_saturate_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
